// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the single-bus core.
// Walks a shared fetch (T0-T2), then per-opcode execute states, and owns
// the run/halt status. Only IR[31:27] is decoded here; register fields
// are left to select_encode.
module control_unit #(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        IRout,
  output logic        MDRout,
  output logic        INout,
  output logic        Cout,
  output logic        Yout,
  output logic        MARout,
  output logic        Read,
  output logic        IncPC,
  output logic        Write,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        IRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        MDRin,
  output logic        CONin,
  output logic        OUT_Portin,
  output logic        CON_RESET,
  output logic        Run
);

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t state_q, state_d;
  logic [4:0] opcode;
  logic unusedIr;

  logic isRegAlu, isImmAlu, isLdi, isLd, isSt, isMulDiv, isNegNot, isBr;
  logic isJr, isJal, isIn, isOut, isMf, isNop, isHalt, isUndef;

  assign opcode   = IR[31:27];
  assign unusedIr = ^IR[26:0];

  assign isRegAlu = (opcode >= OP_ADD) && (opcode <= OP_SHL);
  assign isImmAlu = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
  assign isLdi    = (opcode == OP_LDI);
  assign isLd     = (opcode == OP_LD);
  assign isSt     = (opcode == OP_ST);
  assign isMulDiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign isNegNot = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign isBr     = (opcode == OP_BR);
  assign isJr     = (opcode == OP_JR);
  assign isJal    = (opcode == OP_JAL);
  assign isIn     = (opcode == OP_IN);
  assign isOut    = (opcode == OP_OUT);
  assign isMf     = (opcode == OP_MFHI) || (opcode == OP_MFLO);
  assign isNop    = (opcode == OP_NOP);
  assign isHalt   = (opcode == OP_HALT);
  assign isUndef  = (opcode > OP_HALT);

  // State register; reset parks the sequencer at the start of fetch.
  always_ff @(posedge clk) begin
    if (reset) state_q <= T0;
    else       state_q <= state_d;
  end

  // Next-state: shared fetch, then each opcode leaves at its last execute step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      T0: state_d = stop ? HALT : T1;
      T1: state_d = T2;
      T2: begin
        if (isNop)        state_d = T0;
        else if (isHalt)  state_d = HALT;
        else if (isUndef) state_d = HALT_ON_UNDEF ? HALT : T0;
        else              state_d = T3;
      end
      T3: state_d = (isJr || isIn || isOut || isMf) ? T0 : T4;
      T4: state_d = isNegNot ? T0 : T5;
      T5: state_d = (isRegAlu || isImmAlu || isLdi || isJal) ? T0 : T6;
      T6: state_d = (isMulDiv || isBr) ? T0 : T7;
      T7: state_d = T0;
      HALT: state_d = HALT;
      default: state_d = T0;
    endcase
  end

  // Control word decode from state and opcode; reset forces everything idle except CON_RESET.
  always_comb begin
    HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; PCout = 1'b0;
    IRout = 1'b0; MDRout = 1'b0; INout = 1'b0; Cout = 1'b0; Yout = 1'b0; MARout = 1'b0;
    Read = 1'b0; IncPC = 1'b0; Write = 1'b0;
    AND = 1'b0; OR = 1'b0; ADD = 1'b0; SUB = 1'b0; MUL = 1'b0; DIV = 1'b0; SHR = 1'b0;
    SHRA = 1'b0; SHL = 1'b0; ROR = 1'b0; ROL = 1'b0; NEG = 1'b0; NOT = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; PCin = 1'b0; IRin = 1'b0; Zin = 1'b0; Yin = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; CONin = 1'b0; OUT_Portin = 1'b0;
    CON_RESET = 1'b0; Run = 1'b0;
    if (reset) begin
      CON_RESET = 1'b1;
    end else begin
      Run = (state_q != HALT);
      case (state_q)
        T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; CON_RESET = 1'b1; end
        T1: begin Read = 1'b1; MDRin = 1'b1; end
        T2: begin MDRout = 1'b1; IRin = 1'b1; end
        T3: begin
          if (isRegAlu || isImmAlu) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          if (isLdi || isLd || isSt) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          if (isMulDiv) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          if (isNegNot) begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
            NEG = (opcode == OP_NEG);
            NOT = (opcode == OP_NOT);
          end
          if (isBr)  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          if (isJr)  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          if (isJal) begin PCout = 1'b1; Yin = 1'b1; end
          if (isIn)  begin INout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          if (isOut) begin Gra = 1'b1; Rout = 1'b1; OUT_Portin = 1'b1; end
          if (isMf) begin
            HIout = (opcode == OP_MFHI);
            LOout = (opcode == OP_MFLO);
            Gra = 1'b1; Rin = 1'b1;
          end
        end
        T4: begin
          if (isRegAlu || isImmAlu) begin
            case (opcode)
              OP_ADD, OP_ADDI: ADD = 1'b1;
              OP_SUB:          SUB = 1'b1;
              OP_AND, OP_ANDI: AND = 1'b1;
              OP_OR, OP_ORI:   OR = 1'b1;
              OP_ROR:          ROR = 1'b1;
              OP_ROL:          ROL = 1'b1;
              OP_SHR:          SHR = 1'b1;
              OP_SHRA:         SHRA = 1'b1;
              OP_SHL:          SHL = 1'b1;
              default:         ;
            endcase
            Zin = 1'b1;
            if (isRegAlu) begin Grc = 1'b1; Rout = 1'b1; end
            else          Cout = 1'b1;
          end
          if (isLdi || isLd || isSt) begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
          if (isMulDiv) begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
            MUL = (opcode == OP_MUL);
            DIV = (opcode == OP_DIV);
          end
          if (isNegNot) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          if (isBr)     begin PCout = 1'b1; Yin = 1'b1; end
          if (isJal)    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        end
        T5: begin
          if (isRegAlu || isImmAlu || isLdi) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          if (isLd || isSt) begin Zlowout = 1'b1; MARin = 1'b1; end
          if (isMulDiv)     begin Zlowout = 1'b1; LOin = 1'b1; end
          if (isBr)         begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
          if (isJal)        begin Yout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
        end
        T6: begin
          if (isLd)     begin Read = 1'b1; MDRin = 1'b1; end
          if (isSt)     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          if (isMulDiv) begin Zhighout = 1'b1; HIin = 1'b1; end
          if (isBr && CON) begin Zlowout = 1'b1; PCin = 1'b1; end
        end
        T7: begin
          if (isLd) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          if (isSt) Write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  busSourceOneHot: assert property (@(posedge clk)
    $onehot0({HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout,
              Cout, Yout, MARout, Rout, BAout}));

  aluOpOneHot: assert property (@(posedge clk)
    $onehot0({AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT}));

  regSelectOneHot: assert property (@(posedge clk) $onehot0({Gra, Grb, Grc}));

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed instruction sequences for control_unit.
// Stimulus pushes the hand-written control word expected for each cycle;
// an independent monitor pops and compares it on the falling edge.
module tb_control_unit;

  logic clk, reset, CON, stop;
  logic [31:0] IR;
  logic HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout;
  logic Read, IncPC, Write;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
  logic CON_RESET, Run;

  control_unit #(.HALT_ON_UNDEF(1'b0)) dut (
    .clk(clk), .reset(reset), .IR(IR), .CON(CON), .stop(stop),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .IRout(IRout), .MDRout(MDRout), .INout(INout), .Cout(Cout),
    .Yout(Yout), .MARout(MARout), .Read(Read), .IncPC(IncPC), .Write(Write),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR),
    .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .MDRin(MDRin), .CONin(CONin), .OUT_Portin(OUT_Portin),
    .CON_RESET(CON_RESET), .Run(Run)
  );

  localparam logic [44:0] ONE = 45'd1;
  localparam logic [44:0] M_HIOUT = ONE << 0,  M_LOOUT = ONE << 1,  M_ZHI = ONE << 2;
  localparam logic [44:0] M_ZLO = ONE << 3,    M_PCOUT = ONE << 4,  M_IROUT = ONE << 5;
  localparam logic [44:0] M_MDROUT = ONE << 6, M_INOUT = ONE << 7,  M_COUT = ONE << 8;
  localparam logic [44:0] M_YOUT = ONE << 9,   M_MAROUT = ONE << 10, M_READ = ONE << 11;
  localparam logic [44:0] M_INCPC = ONE << 12, M_WRITE = ONE << 13, M_AND = ONE << 14;
  localparam logic [44:0] M_OR = ONE << 15,    M_ADD = ONE << 16,   M_SUB = ONE << 17;
  localparam logic [44:0] M_MUL = ONE << 18,   M_DIV = ONE << 19,   M_SHR = ONE << 20;
  localparam logic [44:0] M_SHRA = ONE << 21,  M_SHL = ONE << 22,   M_ROR = ONE << 23;
  localparam logic [44:0] M_ROL = ONE << 24,   M_NEG = ONE << 25,   M_NOT = ONE << 26;
  localparam logic [44:0] M_GRA = ONE << 27,   M_GRB = ONE << 28,   M_GRC = ONE << 29;
  localparam logic [44:0] M_RIN = ONE << 30,   M_ROUT = ONE << 31,  M_BAOUT = ONE << 32;
  localparam logic [44:0] M_HIIN = ONE << 33,  M_LOIN = ONE << 34,  M_PCIN = ONE << 35;
  localparam logic [44:0] M_IRIN = ONE << 36,  M_ZIN = ONE << 37,   M_YIN = ONE << 38;
  localparam logic [44:0] M_MARIN = ONE << 39, M_MDRIN = ONE << 40, M_CONIN = ONE << 41;
  localparam logic [44:0] M_OUTP = ONE << 42,  M_CRST = ONE << 43,  M_RUN = ONE << 44;

  localparam logic [44:0] F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_CRST;
  localparam logic [44:0] F1 = M_RUN | M_READ | M_MDRIN;
  localparam logic [44:0] F2 = M_RUN | M_MDROUT | M_IRIN;
  localparam logic [44:0] IDLE = '0;

  localparam logic [31:0] I_ADD  = 32'h1891_8000;
  localparam logic [31:0] I_SHR  = 32'h4891_8000;
  localparam logic [31:0] I_ADDI = 32'h6088_0005;
  localparam logic [31:0] I_LD   = 32'h0088_0010;
  localparam logic [31:0] I_ST   = 32'h1088_0010;
  localparam logic [31:0] I_BR   = 32'h9880_0004;
  localparam logic [31:0] I_MUL  = 32'h7918_0000;
  localparam logic [31:0] I_JAL  = 32'hA8F8_0000;
  localparam logic [31:0] I_NEG  = 32'h8910_0000;
  localparam logic [31:0] I_MFHI = 32'hC080_0000;
  localparam logic [31:0] I_NOP  = 32'hD000_0000;
  localparam logic [31:0] I_UNDF = 32'hE000_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;

  typedef struct {
    logic [44:0] exp;
    string       name;
  } expect_t;

  expect_t sb[$];
  int checkCount = 0;
  int errorCount = 0;
  logic [44:0] obs;

  assign obs = {Run, CON_RESET, OUT_Portin, CONin, MDRin, MARin, Yin, Zin, IRin, PCin,
                LOin, HIin, BAout, Rout, Rin, Grc, Grb, Gra, NOT, NEG, ROL, ROR, SHL,
                SHRA, SHR, DIV, MUL, SUB, ADD, OR, AND, Write, IncPC, Read, MARout,
                Yout, Cout, INout, MDRout, IRout, PCout, Zlowout, Zhighout, LOout, HIout};

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the rising edge and queue its expected control word
  task automatic applyStimulus(input logic [31:0] ir, input logic con, input logic st,
                               input logic rst, input logic [44:0] exp, input string name);
    expect_t e;
    @(posedge clk);
    #1;
    IR = ir; CON = con; stop = st; reset = rst;
    e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] ir, input string name);
    applyStimulus(ir, 1'b0, 1'b0, 1'b0, F0, {name, " T0"});
    applyStimulus(ir, 1'b0, 1'b0, 1'b0, F1, {name, " T1"});
    applyStimulus(ir, 1'b0, 1'b0, 1'b0, F2, {name, " T2"});
  endtask

  task automatic exec(input logic [31:0] ir, input logic [44:0] exp, input string name);
    applyStimulus(ir, 1'b0, 1'b0, 1'b0, M_RUN | exp, name);
  endtask

  task automatic checkOutput(input expect_t e);
    checkCount++;
    if (obs !== e.exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", e.name, obs, e.exp);
    end
  endtask

  // Monitor: compare the DUT control word against the scoreboard mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    reset = 1'b1; IR = '0; CON = 1'b0; stop = 1'b0;

    applyStimulus(I_NOP, 1'b0, 1'b0, 1'b1, M_CRST, "reset cycle 0");
    applyStimulus(I_NOP, 1'b0, 1'b0, 1'b1, M_CRST, "reset cycle 1");

    fetch(I_ADD, "add");
    exec(I_ADD, M_GRB | M_ROUT | M_YIN, "add T3");
    exec(I_ADD, M_GRC | M_ROUT | M_ADD | M_ZIN, "add T4");
    exec(I_ADD, M_ZLO | M_GRA | M_RIN, "add T5");

    fetch(I_SHR, "shr");
    exec(I_SHR, M_GRB | M_ROUT | M_YIN, "shr T3");
    exec(I_SHR, M_GRC | M_ROUT | M_SHR | M_ZIN, "shr T4");
    exec(I_SHR, M_ZLO | M_GRA | M_RIN, "shr T5");

    fetch(I_ADDI, "addi");
    exec(I_ADDI, M_GRB | M_ROUT | M_YIN, "addi T3");
    exec(I_ADDI, M_COUT | M_ADD | M_ZIN, "addi T4");
    exec(I_ADDI, M_ZLO | M_GRA | M_RIN, "addi T5");

    fetch(I_LD, "ld");
    exec(I_LD, M_GRB | M_BAOUT | M_YIN, "ld T3");
    exec(I_LD, M_COUT | M_ADD | M_ZIN, "ld T4");
    exec(I_LD, M_ZLO | M_MARIN, "ld T5");
    exec(I_LD, M_READ | M_MDRIN, "ld T6");
    exec(I_LD, M_MDROUT | M_GRA | M_RIN, "ld T7");
    fetch(I_ST, "st");
    exec(I_ST, M_GRB | M_BAOUT | M_YIN, "st T3");
    exec(I_ST, M_COUT | M_ADD | M_ZIN, "st T4");
    exec(I_ST, M_ZLO | M_MARIN, "st T5");
    exec(I_ST, M_GRA | M_ROUT | M_MDRIN, "st T6");
    exec(I_ST, M_WRITE, "st T7");

    fetch(I_BR, "br taken");
    applyStimulus(I_BR, 1'b1, 1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_CONIN, "br taken T3");
    applyStimulus(I_BR, 1'b1, 1'b0, 1'b0, M_RUN | M_PCOUT | M_YIN, "br taken T4");
    applyStimulus(I_BR, 1'b1, 1'b0, 1'b0, M_RUN | M_COUT | M_ADD | M_ZIN, "br taken T5");
    applyStimulus(I_BR, 1'b1, 1'b0, 1'b0, M_RUN | M_ZLO | M_PCIN, "br taken T6");
    fetch(I_BR, "br not taken");
    applyStimulus(I_BR, 1'b0, 1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_CONIN, "br not taken T3");
    applyStimulus(I_BR, 1'b0, 1'b0, 1'b0, M_RUN | M_PCOUT | M_YIN, "br not taken T4");
    applyStimulus(I_BR, 1'b0, 1'b0, 1'b0, M_RUN | M_COUT | M_ADD | M_ZIN, "br not taken T5");
    applyStimulus(I_BR, 1'b0, 1'b0, 1'b0, M_RUN, "br not taken T6");

    fetch(I_MUL, "mul");
    exec(I_MUL, M_GRA | M_ROUT | M_YIN, "mul T3");
    exec(I_MUL, M_GRB | M_ROUT | M_MUL | M_ZIN, "mul T4");
    exec(I_MUL, M_ZLO | M_LOIN, "mul T5");
    exec(I_MUL, M_ZHI | M_HIIN, "mul T6");

    fetch(I_JAL, "jal");
    exec(I_JAL, M_PCOUT | M_YIN, "jal T3");
    exec(I_JAL, M_GRA | M_ROUT | M_PCIN, "jal T4");
    exec(I_JAL, M_YOUT | M_GRB | M_RIN, "jal T5");

    fetch(I_NEG, "neg");
    exec(I_NEG, M_GRB | M_ROUT | M_NEG | M_ZIN, "neg T3");
    exec(I_NEG, M_ZLO | M_GRA | M_RIN, "neg T4");

    fetch(I_MFHI, "mfhi");
    exec(I_MFHI, M_HIOUT | M_GRA | M_RIN, "mfhi T3");

    fetch(I_NOP, "nop");
    fetch(I_UNDF, "undefined as nop");

    fetch(I_HALT, "halt");
    for (int i = 0; i < 20; i++) applyStimulus(I_NOP, 1'b0, 1'b0, 1'b0, IDLE, "halt idle");
    applyStimulus(I_NOP, 1'b0, 1'b0, 1'b1, M_CRST, "reset in halt");
    fetch(I_MFHI, "mfhi after halt");
    exec(I_MFHI, M_HIOUT | M_GRA | M_RIN, "mfhi after halt T3");

    applyStimulus(I_NOP, 1'b0, 1'b1, 1'b0, F0, "stop T0");
    for (int i = 0; i < 20; i++) applyStimulus(I_NOP, 1'b0, 1'b0, 1'b0, IDLE, "stop idle");
    applyStimulus(I_NOP, 1'b0, 1'b0, 1'b1, M_CRST, "reset after stop");

    fetch(I_LD, "ld aborted");
    exec(I_LD, M_GRB | M_BAOUT | M_YIN, "ld aborted T3");
    applyStimulus(I_LD, 1'b0, 1'b0, 1'b1, M_CRST, "reset in ld T4");
    fetch(I_NOP, "nop after abort");
    fetch(I_NOP, "nop second");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired, Moore-style instruction sequencer that drives every control input of `core`.
- Fetches through PC/MAR/MDR/IR, then steps through per-opcode execute states.
- Decodes opcode IR[31:27] only; register-field decode stays in select_encode.
- Owns run/halt status for the CPU top level.

Parameters:
HALT_ON_UNDEF, 0, undefined opcode handling: 0 = execute as nop, 1 = enter HALT

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
IR  input  32  instruction register from core; opcode = IR[31:27]
CON  input  1  branch condition flip-flop output from datapath
stop  input  1  external halt request, sampled in T0
HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout  output  1 each  bus source selects
Read, IncPC, Write  output  1 each  memory read, PC increment, memory write strobe
AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT  output  1 each  ALU op, one-hot or all zero
Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  to select_encode
HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin  output  1 each  register load enables
CON_RESET  output  1  clears CON flip-flop
Run  output  1  1 while executing, 0 in HALT and during reset

Behaviour:
- State register: T0..T7 plus HALT.
- All outputs decode combinationally from state and opcode only, with no input-to-output paths except CON in br T6.
- Any signal not listed for a state is 0.
- Reset:
  - While reset=1: all outputs 0 except CON_RESET=1; Run=0.
  - First cycle after reset falls: T0.
  - Reset mid-instruction aborts it in that cycle.
  - Reset exits HALT.
- Fetch, all opcodes:
  - T0: PCout, MARin, IncPC, CON_RESET.
  - T1: Read, MDRin.
  - T2: MDRout, IRin.
- T0 stop: if stop=1 in T0, T0 outputs still assert and the next state is HALT.
- Opcode map IR[31:27]:
  - ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, ror=00111, rol=01000
  - shr=01001, shra=01010, shl=01011, addi=01100, andi=01101, ori=01110, mul=01111, div=10000
  - neg=10001, not=10010, br=10011, jr=10100, jal=10101, in=10110, out=10111, mfhi=11000, mflo=11001, nop=11010, halt=11011
- Execute sequences; the last listed state returns to T0:
  - reg ALU (add..shl): T3 Grb,Rout,Yin; T4 Grc,Rout,op,Zin; T5 Zlowout,Gra,Rin.
  - imm ALU: addi/andi/ori use ADD/AND/OR. T3 Grb,Rout,Yin; T4 Cout,op,Zin; T5 Zlowout,Gra,Rin.
  - ldi: T3 Grb,BAout,Yin; T4 Cout,ADD,Zin; T5 Zlowout,Gra,Rin.
  - ld: ldi T3-T4, then T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
  - st: ldi T3-T4, then T5 Zlowout,MARin; T6 Gra,Rout,MDRin (Read=0 selects bus); T7 Write.
  - mul/div: T3 Gra,Rout,Yin; T4 Grb,Rout,MUL|DIV,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin.
  - neg/not: T3 Grb,Rout,NEG|NOT,Zin; T4 Zlowout,Gra,Rin.
  - br: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,ADD,Zin; T6 Zlowout,PCin only if CON=1. T6 occurs either way: fixed 7 cycles.
  - jr: T3 Gra,Rout,PCin.
  - jal: T3 PCout,Yin; T4 Gra,Rout,PCin; T5 Yout,Grb,Rin. Link register is the Rb field; the assembler sets Rb=15.
  - in: T3 INout,Gra,Rin. out: T3 Gra,Rout,OUT_Portin.
  - mfhi/mflo: T3 HIout|LOout,Gra,Rin.
  - nop: T2 goes to T0.
  - halt: T2 goes to HALT.
- Undefined opcodes 11100-11111 behave per HALT_ON_UNDEF.
- HALT: all outputs 0, Run=0, remain until reset.
- Invariants, checked by assertion:
  - At most one bus source asserted per cycle, counting Rout via select_encode.
  - At most one ALU op asserted.
  - Gra, Grb, Grc mutually exclusive.
- Cycle counts per instruction, including fetch: reg/imm ALU 6, ld/st 8, ldi 6, mul/div 7, neg/not 5, br 7, jal 6, jr/in/out/mfhi/mflo 4, nop 3.

Test Plan:
- Reset held 2 cycles → outputs 0, CON_RESET=1, Run=0; first cycle after release: PCout=MARin=IncPC=1.
- IR=0x18918000 (add R1,R2,R3) → T3 Grb/Rout/Yin, T4 Grc/Rout/ADD/Zin, T5 Zlowout/Gra/Rin; PCout reasserts on cycle 7.
- ld then st back-to-back → Read+MDRin in T1 and T6 of ld; Write high exactly one cycle, in st T7; 16 cycles total.
- br with CON=1 then CON=0 → PCin asserted in T6 only for the taken case; both take 7 cycles; CON_RESET pulses each T0.
- mul → LOin in T5, HIin in T6, 7 cycles; jal with Rb=15 → PCin T4, Yout+Grb+Rin T5.
- halt opcode, and separately stop=1 in T0 → Run falls and outputs stay 0 for 20 cycles; reset mid-HALT and mid-ld T4 → restarts at T0.
